// File: rtl/rv_mem_pkg.sv
// Shared RV32I memory types: funct3 codes, response causes, FSM states, response payload.
package rv_mem_pkg;

   localparam logic [2:0] MEM_SB  = 3'd0;
   localparam logic [2:0] MEM_SH  = 3'd1;
   localparam logic [2:0] MEM_SW  = 3'd2;
   localparam logic [2:0] MEM_LB  = 3'd0;
   localparam logic [2:0] MEM_LH  = 3'd1;
   localparam logic [2:0] MEM_LW  = 3'd2;
   localparam logic [2:0] MEM_LBU = 3'd4;
   localparam logic [2:0] MEM_LHU = 3'd5;

   typedef enum logic [1:0] {
      CAUSE_OK       = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_RANGE    = 2'b10,
      CAUSE_ILLEGAL  = 2'b11
   } cause_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   typedef struct packed {
      logic        err;
      cause_e      cause;
      logic [31:0] rdata;
   } resp_t;

endpackage

// File: rtl/dmem_pipelined_if.sv
// Request/response bus between the pipeline and the data memory.
interface dmem_pipelined_if
   import rv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   cause_e            resp_cause;
   logic              init_done;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause, init_done
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_cause, init_done
   );
endinterface

// File: rtl/dmem_bram_be.sv
// Single-port DEPTH_WORDS x 32 RAM, per-byte write enables, synchronous read, no reset.
module dmem_bram_be #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   // One byte-wide array per lane keeps each lane a plain single-writer RAM.
   for (genvar b = 0; b < 4; b++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      // Byte write and read-first registered read of this lane.
      always_ff @(posedge clk) begin
         if (en) begin
            if (we && be[b]) mem[addr] <= wdata[8*b +: 8];
            rd_q <= mem[addr];
         end
      end

      assign rdata[8*b +: 8] = rd_q;
   end

endmodule

// File: rtl/dmem_pipelined.sv
// RV32I data memory: post-reset clear FSM, access decode/checks, BRAM, load formatter, response pipe.
module dmem_pipelined
   import rv_mem_pkg::*;
#(
   parameter int unsigned       DEPTH_WORDS    = 1024,
   parameter int unsigned       ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
   parameter bit                REG_OUT        = 1'b0,
   parameter bit                CLEAR_ON_RESET = 1'b1
) (
   input logic             clk,
   input logic             rst,
   dmem_pipelined_if.slave bus
);

   localparam int unsigned     IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH_WORDS * 4);

   state_e           state, state_nxt;
   logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;
   logic             clr_we_c;
   logic             ready_q, done_q;

   logic [ADDR_W-1:0] off_c;
   logic [IDX_W-1:0]  idx_c;
   logic [1:0]        lane_c;
   logic [2:0]        f3_c;
   logic              acc_c, illegal_c, misalign_c, in_range_c;
   cause_e            cause_c;
   logic [3:0]        be_c;
   logic [31:0]       wdata_sh_c;

   logic              ram_en, ram_we;
   logic [3:0]        ram_be;
   logic [IDX_W-1:0]  ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;

   logic              s1_valid, s1_we;
   logic [2:0]        s1_f3;
   logic [1:0]        s1_lane;
   cause_e            s1_cause;
   logic [31:0]       shifted_c;
   resp_t             fmt_c, out_d;
   logic              out_v_d;
   logic              resp_valid_q;
   resp_t             resp_q;

   // FSM state, clear counter and the registered ready/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_cnt <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         ready_q <= (state_nxt == ST_RUN);
         done_q  <= (state_nxt == ST_RUN);
      end
   end

   // Next state: CLEAR writes one zero word per cycle, then hands over to RUN.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      clr_we_c    = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we_c    = 1'b1;
            clr_cnt_nxt = clr_cnt + IDX_W'(1);
            if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) state_nxt = ST_RUN;
         end
         default: ;
      endcase
   end

   assign f3_c       = bus.req_funct3;
   assign off_c      = bus.req_addr - BASE_ADDR;
   assign idx_c      = off_c[IDX_W+1:2];
   assign lane_c     = off_c[1:0];
   assign in_range_c = ({1'b0, off_c} < SPAN);
   assign acc_c      = bus.req_valid & ready_q & ~rst;
   assign illegal_c  = bus.req_we ? (f3_c > MEM_SW)
                                  : ((f3_c == 3'd3) || (f3_c == 3'd6) || (f3_c == 3'd7));
   assign misalign_c = ((f3_c[1:0] == 2'b01) && lane_c[0]) ||
                       ((f3_c[1:0] == 2'b10) && (lane_c != 2'b00));
   assign wdata_sh_c = bus.req_wdata << {lane_c, 3'b000};

   // Error cause with illegal > misaligned > out-of-range priority.
   always_comb begin
      cause_c = CAUSE_OK;
      if (illegal_c)       cause_c = CAUSE_ILLEGAL;
      else if (misalign_c) cause_c = CAUSE_MISALIGN;
      else if (!in_range_c) cause_c = CAUSE_RANGE;
   end

   // Store byte enables from access size and lane.
   always_comb begin
      be_c = 4'b0000;
      case (f3_c[1:0])
         2'b00:   be_c = 4'b0001 << lane_c;
         2'b01:   be_c = 4'b0011 << lane_c;
         default: be_c = 4'b1111;
      endcase
   end

   // The clear sequence owns the RAM port; no requests are accepted meanwhile.
   assign ram_en    = clr_we_c | acc_c;
   assign ram_we    = clr_we_c | (acc_c & bus.req_we & (cause_c == CAUSE_OK));
   assign ram_be    = clr_we_c ? 4'b1111 : be_c;
   assign ram_addr  = clr_we_c ? clr_cnt : idx_c;
   assign ram_wdata = clr_we_c ? 32'd0 : wdata_sh_c;

   dmem_bram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (ram_be),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Request attributes travel alongside the RAM read.
   always_ff @(posedge clk) begin
      if (rst) s1_valid <= 1'b0;
      else     s1_valid <= acc_c;
      if (acc_c) begin
         s1_we    <= bus.req_we;
         s1_f3    <= f3_c;
         s1_lane  <= lane_c;
         s1_cause <= cause_c;
      end
   end

   // Load formatter: lane select plus sign/zero extension; zero for stores and errors.
   always_comb begin
      shifted_c   = ram_rdata >> {s1_lane, 3'b000};
      fmt_c       = '0;
      fmt_c.cause = s1_cause;
      fmt_c.err   = (s1_cause != CAUSE_OK);
      if (!fmt_c.err && !s1_we) begin
         case (s1_f3)
            MEM_LB:  fmt_c.rdata = {{24{shifted_c[7]}}, shifted_c[7:0]};
            MEM_LH:  fmt_c.rdata = {{16{shifted_c[15]}}, shifted_c[15:0]};
            MEM_LBU: fmt_c.rdata = {24'd0, shifted_c[7:0]};
            MEM_LHU: fmt_c.rdata = {16'd0, shifted_c[15:0]};
            default: fmt_c.rdata = shifted_c;
         endcase
      end
   end

   if (REG_OUT) begin : g_reg_out
      logic  s2_valid;
      resp_t s2_resp;

      // Extra stage between the formatter and the output register.
      always_ff @(posedge clk) begin
         if (rst) begin
            s2_valid <= 1'b0;
            s2_resp  <= '0;
         end else begin
            s2_valid <= s1_valid;
            s2_resp  <= fmt_c;
         end
      end

      assign out_v_d = s2_valid;
      assign out_d   = s2_resp;
   end else begin : g_direct
      assign out_v_d = s1_valid;
      assign out_d   = fmt_c;
   end

   // Output register; the payload holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
      end else begin
         resp_valid_q <= out_v_d;
         if (out_v_d) resp_q <= out_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.init_done  = done_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_q.rdata;
   assign bus.resp_err   = resp_q.err;
   assign bus.resp_cause = resp_q.cause;

endmodule

// File: tb/tb_dmem_pipelined.sv
// Scoreboard bench: two DUTs (REG_OUT 0 and 1) share one request stream and a byte-level model.
module tb_dmem_pipelined;
   import rv_mem_pkg::*;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned MEM_B  = DEPTH * 4;
   localparam int unsigned MEM_AW = $clog2(MEM_B);
   localparam logic [31:0] BASE   = 32'h0;
   localparam logic [31:0] SPAN   = 32'(MEM_B);

   typedef struct packed {
      int          edge_n;
      logic        err;
      logic [1:0]  cause;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [7:0] mem_m [MEM_B];

   dmem_pipelined_if #(.ADDR_W(32)) bus0 ();
   dmem_pipelined_if #(.ADDR_W(32)) bus1 ();

   assign bus1.req_valid  = bus0.req_valid;
   assign bus1.req_we     = bus0.req_we;
   assign bus1.req_funct3 = bus0.req_funct3;
   assign bus1.req_addr   = bus0.req_addr;
   assign bus1.req_wdata  = bus0.req_wdata;

   dmem_pipelined #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE),
                    .REG_OUT(1'b0), .CLEAR_ON_RESET(1'b1))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));

   dmem_pipelined #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE),
                    .REG_OUT(1'b1), .CLEAR_ON_RESET(1'b1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference behaviour straight from the access rules, over a byte array.
   function automatic exp_t model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
      exp_t              e;
      logic [31:0]       off;
      logic [31:0]       v;
      logic [MEM_AW-1:0] bi;
      int                size;
      logic              illegal;
      e    = '0;
      off  = addr - BASE;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      illegal = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 >= 3'd6));
      if (illegal)                      e.cause = 2'd3;
      else if ((off % 32'(size)) != 0)  e.cause = 2'd1;
      else if (off >= SPAN)             e.cause = 2'd2;
      e.err = (e.cause != 2'd0);
      if (!e.err) begin
         v = 32'd0;
         for (int b = 0; b < size; b++) begin
            bi = MEM_AW'(off + 32'(b));
            if (we) mem_m[bi] = wdata[8*b +: 8];
            else    v[8*b +: 8] = mem_m[bi];
         end
         if (!we && f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
         if (!we && f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
         e.rdata = we ? 32'd0 : v;
      end
      return e;
   endfunction

   function automatic void check_resp(input string tag, input exp_t e, input int lat,
                                      input logic err, input logic [1:0] cause,
                                      input logic [31:0] rdata);
      chk({tag, " latency"}, 32'(cyc), 32'(e.edge_n + lat));
      chk({tag, " err"},     32'(err), 32'(e.err));
      chk({tag, " cause"},   32'(cause), 32'(e.cause));
      chk({tag, " rdata"},   rdata, e.rdata);
   endfunction

   // Caller sits at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      int   n;
      n = 0;
      bus0.req_valid = 1'b0;
      while (bus0.req_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (bus0.req_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: req_ready stayed %b, required 1", bus0.req_ready);
         return;
      end
      bus0.req_valid  = 1'b1;
      bus0.req_we     = we;
      bus0.req_funct3 = f3;
      bus0.req_addr   = addr;
      bus0.req_wdata  = wdata;
      e = model(we, f3, addr, wdata);
      e.edge_n = cyc + 1;
      q0.push_back(e);
      q1.push_back(e);
      @(negedge clk);
      bus0.req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus0.req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // One-cycle reset, check reset outputs, then time the clear sequence.
   task automatic do_reset();
      int n;
      rst = 1'b1;
      bus0.req_valid = 1'b0;
      q0.delete();
      q1.delete();
      for (int i = 0; i < MEM_B; i++) mem_m[i] = 8'h00;
      @(negedge clk);
      chk("rst req_ready0",  32'(bus0.req_ready), 32'd0);
      chk("rst resp_valid0", 32'(bus0.resp_valid), 32'd0);
      chk("rst resp_rdata0", bus0.resp_rdata, 32'd0);
      chk("rst resp_err0",   32'(bus0.resp_err), 32'd0);
      chk("rst resp_cause0", 32'(bus0.resp_cause), 32'd0);
      chk("rst init_done0",  32'(bus0.init_done), 32'd0);
      chk("rst resp_valid1", 32'(bus1.resp_valid), 32'd0);
      chk("rst init_done1",  32'(bus1.init_done), 32'd0);
      rst = 1'b0;
      n = 0;
      while (bus0.req_ready !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("clear cycles",   32'(n), 32'(DEPTH));
      chk("init_done0",     32'(bus0.init_done), 32'd1);
      chk("init_done1",     32'(bus1.init_done), 32'd1);
      chk("req_ready1",     32'(bus1.req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      rst = 1'b1;
      bus0.req_valid  = 1'b0;
      bus0.req_we     = 1'b0;
      bus0.req_funct3 = 3'd0;
      bus0.req_addr   = 32'd0;
      bus0.req_wdata  = 32'd0;

      // Monitor: pops the expected response for each DUT whenever resp_valid is seen.
      fork
         forever begin
            @(negedge clk);
            if (bus0.resp_valid === 1'b1) begin
               if (q0.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL dut0 unexpected resp_valid at cycle %0d, required none", cyc);
               end else begin
                  check_resp("dut0", q0.pop_front(), 1, bus0.resp_err, bus0.resp_cause, bus0.resp_rdata);
               end
            end
            if (bus1.resp_valid === 1'b1) begin
               if (q1.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL dut1 unexpected resp_valid at cycle %0d, required none", cyc);
               end else begin
                  check_resp("dut1", q1.pop_front(), 2, bus1.resp_err, bus1.resp_cause, bus1.resp_rdata);
               end
            end
         end
      join_none

      @(negedge clk);
      do_reset();

      // Freshly cleared array reads zero everywhere.
      for (int i = 0; i < DEPTH; i++) issue(1'b0, MEM_LW, 32'(i * 4), 32'd0);

      // Byte/half extraction with sign and zero extension.
      issue(1'b1, MEM_SW,  32'h8, 32'hDEADBEEF);
      issue(1'b0, MEM_LB,  32'h8, 32'd0);
      issue(1'b0, MEM_LBU, 32'hB, 32'd0);
      issue(1'b0, MEM_LH,  32'hA, 32'd0);
      issue(1'b0, MEM_LHU, 32'h8, 32'd0);

      // Byte store merge, read back on the very next cycle.
      issue(1'b1, MEM_SW, 32'h8, 32'h11223344);
      issue(1'b1, MEM_SB, 32'h9, 32'h0000005A);
      issue(1'b0, MEM_LW, 32'h8, 32'd0);

      // Error cases and their priority; the rejected SH must leave word 0 intact.
      issue(1'b1, MEM_SW, 32'h0, 32'hCAFEF00D);
      issue(1'b0, MEM_LW, 32'h6, 32'd0);
      issue(1'b1, MEM_SH, 32'h3, 32'h0000FFFF);
      issue(1'b0, MEM_LW, 32'h0, 32'd0);
      issue(1'b0, MEM_LW, SPAN, 32'd0);
      issue(1'b0, 3'b011, 32'h0, 32'd0);
      issue(1'b1, 3'b011, 32'h0, 32'h12345678);
      issue(1'b0, 3'b011, 32'h6, 32'd0);
      issue(1'b1, MEM_SH, SPAN + 32'd1, 32'd0);
      issue(1'b0, MEM_LW, 32'hFFFF_FFFC, 32'd0);
      issue(1'b0, MEM_LW, 32'h0, 32'd0);
      idle(3);

      // Four back-to-back loads.
      for (int i = 0; i < 4; i++) issue(1'b0, MEM_LW, 32'(i * 4 + 4), 32'd0);
      idle(3);

      // Randomised mix with idle gaps.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            case ($urandom_range(0, 9))
               0:       a = SPAN + 32'($urandom_range(0, 63));
               1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               default: a = 32'($urandom_range(0, MEM_B - 1));
            endcase
            f3 = 3'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), f3, a, $urandom);
         end
      end
      idle(4);

      // Reset one cycle after accepting a load: it must vanish, and the clear wipes memory.
      issue(1'b1, MEM_SW, 32'h0, 32'hA5A5A5A5);
      idle(3);
      issue(1'b0, MEM_LW, 32'h0, 32'd0);
      do_reset();
      issue(1'b0, MEM_LW, 32'h0, 32'd0);
      issue(1'b0, MEM_LW, 32'h8, 32'd0);
      idle(6);

      chk("dut0 pending responses", 32'(q0.size()), 32'd0);
      chk("dut1 pending responses", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
